// File: rtl/diff_arbiter.sv
// Round-robin arbiter sharing one multi-cycle lowest-differing-bit unit between
// the execute-stage ALU (requester 0) and the branch/compare unit (requester 1).

module diff (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [5:0]  index
);
  logic [31:0] x;
  logic [31:0] lowest;

  // Two's-complement isolation of the lowest set bit. The 32-bit carry ripple is
  // the slow path that forces the arbiter to hold operands for a settle window.
  assign x      = a ^ b;
  assign lowest = x & (~x + 32'd1);

  always_comb begin
    index = '0;
    for (int i = 0; i < 32; i++) begin
      if (lowest[i]) index = index | 6'(i);
    end
  end
endmodule

module diff_arbiter #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [31:0]      a0,
  input  logic [31:0]      b0,
  input  logic             req1,
  input  logic [31:0]      a1,
  input  logic [31:0]      b1,
  output logic             done0,
  output logic             done1,
  output logic [5:0]       result,
  output logic             eq,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        owner;
  logic        last_grant;
  logic        grant_any;
  logic        grant_idx;
  logic        settle_last;
  logic        operands_eq;
  logic [5:0]  diff_idx;

  // The diff unit only ever sees the latched operands, never the ports.
  diff u_diff (
    .a     (op_a),
    .b     (op_b),
    .index (diff_idx)
  );

  // On a tie the requester that did not win last time gets the grant.
  assign grant_any   = req0 | req1;
  assign grant_idx   = (req0 && req1) ? ~last_grant : req1;
  assign settle_last = (cnt == 4'(SETTLE_CYCLES - 1));
  assign operands_eq = (op_a == op_b);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = SETTLE;
      SETTLE:  if (settle_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      result     <= '0;
      eq         <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_a       <= grant_idx ? a1 : a0;
            op_b       <= grant_idx ? b1 : b0;
            owner      <= grant_idx;
            last_grant <= grant_idx;
            cnt        <= '0;
          end
        end
        SETTLE: begin
          if (settle_last) begin
            result <= operands_eq ? 6'd0 : diff_idx;
            eq     <= operands_eq;
            done0  <= ~owner;
            done1  <= owner;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          done0    <= 1'b0;
          done1    <= 1'b0;
          op_count <= op_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_diff_arbiter.sv
// Bench for diff_arbiter: two instances (slow/wide counter and fast/narrow counter)
// share stimulus and are compared every cycle against a transaction-level model.

module tb_diff_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

  logic        done0_a, done1_a, eq_a, busy_a;
  logic [5:0]  result_a;
  logic [15:0] op_count_a;
  logic        done0_b, done1_b, eq_b, busy_b;
  logic [5:0]  result_b;
  logic [1:0]  op_count_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int m_settle [2] = '{2, 1};
  int m_cntw   [2] = '{16, 2};
  int m_active [2];
  int m_owner  [2];
  int m_last   [2];
  int m_done_edge [2];
  int m_next   [2];
  int m_cnt    [2];
  int m_res    [2];
  int m_eq     [2];
  int m_done_at [2][2];

  always #5 clk = ~clk;

  diff_arbiter #(.SETTLE_CYCLES(2), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .req0(req0), .a0(a0), .b0(b0), .req1(req1), .a1(a1), .b1(b1),
    .done0(done0_a), .done1(done1_a), .result(result_a), .eq(eq_a), .busy(busy_a),
    .op_count(op_count_a)
  );

  diff_arbiter #(.SETTLE_CYCLES(1), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .req0(req0), .a0(a0), .b0(b0), .req1(req1), .a1(a1), .b1(b1),
    .done0(done0_b), .done1(done1_b), .result(result_b), .eq(eq_b), .busy(busy_b),
    .op_count(op_count_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_index(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 32; i++) begin
      if (a[i] != b[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 0;  m_owner[d] = 0;  m_last[d] = 1;
      m_done_edge[d] = -100;  m_next[d] = 0;
      m_cnt[d] = 0;  m_res[d] = 0;  m_eq[d] = 0;
      m_done_at[d][0] = -100;  m_done_at[d][1] = -100;
    end
  endtask

  // An operation granted at edge g finishes at g+S, frees the unit at g+S+1 and
  // the next grant can happen at g+S+2.
  task automatic model_edge(input int d);
    int w;
    logic [31:0] ga, gb;
    if (m_active[d] != 0 && cyc == m_done_edge[d] + 1) begin
      m_active[d] = 0;
      m_cnt[d] = (m_cnt[d] + 1) % (1 << m_cntw[d]);
    end
    if (m_active[d] == 0 && cyc >= m_next[d] && (req0 || req1)) begin
      if (req0 && req1) w = (m_last[d] == 0) ? 1 : 0;
      else              w = req0 ? 0 : 1;
      ga = (w == 1) ? a1 : a0;
      gb = (w == 1) ? b1 : b0;
      m_active[d] = 1;  m_owner[d] = w;  m_last[d] = w;
      m_done_edge[d] = cyc + m_settle[d];
      m_next[d] = cyc + m_settle[d] + 2;
      m_res[d] = ref_index(ga, gb);
      m_eq[d] = (ga == gb) ? 1 : 0;
    end
    if (m_active[d] != 0 && cyc == m_done_edge[d]) m_done_at[d][m_owner[d]] = cyc;
  endtask

  task automatic check_dut(input int d);
    logic o_d0, o_d1, o_eq, o_busy;
    logic [5:0] o_res;
    logic [31:0] o_cnt;
    int in_done;
    if (d == 0) begin
      o_d0 = done0_a; o_d1 = done1_a; o_eq = eq_a; o_busy = busy_a; o_res = result_a; o_cnt = 32'(op_count_a);
    end else begin
      o_d0 = done0_b; o_d1 = done1_b; o_eq = eq_b; o_busy = busy_b; o_res = result_b; o_cnt = 32'(op_count_b);
    end
    in_done = (m_active[d] != 0 && cyc == m_done_edge[d]) ? 1 : 0;
    checkOutput($sformatf("d%0d_done0@%0d", d, cyc), 32'(o_d0), (in_done != 0 && m_owner[d] == 0) ? 32'd1 : 32'd0);
    checkOutput($sformatf("d%0d_done1@%0d", d, cyc), 32'(o_d1), (in_done != 0 && m_owner[d] == 1) ? 32'd1 : 32'd0);
    checkOutput($sformatf("d%0d_busy@%0d", d, cyc), 32'(o_busy), 32'(m_active[d] != 0));
    checkOutput($sformatf("d%0d_count@%0d", d, cyc), o_cnt, 32'(m_cnt[d]));
    if (m_active[d] == 0 || cyc >= m_done_edge[d]) begin
      checkOutput($sformatf("d%0d_result@%0d", d, cyc), 32'(o_res), 32'(m_res[d]));
      checkOutput($sformatf("d%0d_eq@%0d", d, cyc), 32'(o_eq), 32'(m_eq[d]));
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic [31:0] x0, input logic [31:0] y0,
                               input logic r1, input logic [31:0] x1, input logic [31:0] y1);
    req0 = r0; a0 = x0; b0 = y0;
    req1 = r1; a1 = x1; b1 = y1;
  endtask

  task automatic step_cycle();
    @(posedge clk);
    cyc++;
    if (!rst) model_reset();
    else begin
      model_edge(0);
      model_edge(1);
    end
    #1;
    check_dut(0);
    check_dut(1);
    @(negedge clk);
  endtask

  task automatic wait_done(input int d, input int which, input int budget,
                           output int edge_at, output int owner);
    logic d0, d1;
    edge_at = -1;
    owner = -1;
    for (int n = 0; n < budget && edge_at < 0; n++) begin
      step_cycle();
      d0 = (d == 0) ? done0_a : done0_b;
      d1 = (d == 0) ? done1_a : done1_b;
      if (d0 && which != 1) begin edge_at = cyc; owner = 0; end
      else if (d1 && which != 0) begin edge_at = cyc; owner = 1; end
    end
    if (edge_at < 0) checkOutput($sformatf("d%0d_wait_done", d), 32'd0, 32'd1);
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst = 1'b0;
    model_reset();
    #1;
    checkOutput({tag, "_busy"}, 32'(busy_a), 32'd0);
    checkOutput({tag, "_done"}, 32'({done0_a, done1_a, done0_b, done1_b}), 32'd0);
    checkOutput({tag, "_result"}, 32'(result_a), 32'd0);
    checkOutput({tag, "_count"}, 32'(op_count_a), 32'd0);
    step_cycle();
    rst = 1'b1;
  endtask

  function automatic logic [31:0] pick_b(input logic [31:0] a);
    logic [31:0] one;
    one = 32'h1;
    case ($urandom_range(0, 3))
      0:       return a;
      1:       return a ^ (one << $urandom_range(0, 31));
      2:       return a ^ ($urandom & 32'hFFFF_0000);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int s, e, o;
    int owners [4];
    int edges  [4];
    int ress   [4];
    int wrap_exp [5] = '{1, 2, 3, 0, 1};
    logic        pend [2];
    logic [31:0] ra [2];
    logic [31:0] rb [2];

    model_reset();
    applyStimulus(0, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    @(negedge clk);
    step_cycle();
    step_cycle();
    rst = 1'b1;

    // Single request: result 4, latency 3 edges counting the sampling edge.
    applyStimulus(1, 32'h0000_0010, 32'h0, 0, 0, 0);
    s = cyc + 1;
    wait_done(0, 0, 20, e, o);
    checkOutput("single_latency", 32'(e - s + 1), 32'd3);
    checkOutput("single_result", 32'(result_a), 32'd4);
    checkOutput("single_eq", 32'(eq_a), 32'd0);
    step_cycle();
    checkOutput("single_count", 32'(op_count_a), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (6) step_cycle();

    // Equal operands from requester 1.
    applyStimulus(0, 0, 0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    wait_done(0, 1, 20, e, o);
    checkOutput("equal_result", 32'(result_a), 32'd0);
    checkOutput("equal_eq", 32'(eq_a), 32'd1);
    step_cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (6) step_cycle();

    // Continuous tie: grants alternate, done pulses 4 cycles apart.
    applyStimulus(1, 32'h1, 32'h0, 1, 32'h8000_0000, 32'h0);
    for (int j = 0; j < 4; j++) begin
      wait_done(0, 2, 20, e, o);
      owners[j] = o;
      edges[j] = e;
      ress[j] = 32'(result_a);
    end
    for (int j = 0; j < 4; j++) begin
      checkOutput($sformatf("tie_owner%0d", j), 32'(owners[j]), 32'(j % 2));
      checkOutput($sformatf("tie_result%0d", j), 32'(ress[j]), (j % 2 == 1) ? 32'd31 : 32'd0);
      if (j > 0) checkOutput($sformatf("tie_gap%0d", j), 32'(edges[j] - edges[j-1]), 32'd4);
    end
    step_cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (6) step_cycle();

    // Operand change after grant must not affect the captured operation.
    applyStimulus(1, 32'h4, 32'h0, 0, 0, 0);
    step_cycle();
    applyStimulus(1, 32'hFFFF_FFFF, 32'h0, 0, 0, 0);
    wait_done(0, 0, 20, e, o);
    checkOutput("stable_result", 32'(result_a), 32'd2);
    step_cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (6) step_cycle();

    // Reset mid-SETTLE, then a held tie restarts with requester 0 winning.
    applyStimulus(1, 32'h100, 32'h0, 1, 32'h200, 32'h0);
    step_cycle();
    step_cycle();
    async_reset_check("midop_rst");
    s = cyc + 1;
    wait_done(0, 2, 20, e, o);
    checkOutput("rst_tie_owner", 32'(o), 32'd0);
    checkOutput("rst_latency", 32'(e - s + 1), 32'd3);
    checkOutput("rst_result", 32'(result_a), 32'd8);
    step_cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (6) step_cycle();

    // Narrow counter wraps on the fast instance; latency there is 2 edges.
    @(negedge clk);
    async_reset_check("wrap_rst");
    applyStimulus(1, 32'h0000_0C00, 32'h0000_0400, 0, 0, 0);
    s = cyc + 1;
    for (int j = 0; j < 5; j++) begin
      wait_done(1, 0, 20, e, o);
      if (j == 0) checkOutput("fast_latency", 32'(e - s + 1), 32'd2);
      checkOutput($sformatf("fast_result%0d", j), 32'(result_b), 32'd11);
      step_cycle();
      checkOutput($sformatf("wrap_count%0d", j), 32'(op_count_b), 32'(wrap_exp[j]));
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (6) step_cycle();

    // Randomized traffic with occasional resets, judged by the model each cycle.
    pend[0] = 1'b0; pend[1] = 1'b0;
    ra[0] = '0; ra[1] = '0; rb[0] = '0; rb[1] = '0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
      end else begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
          if (pend[i] && m_done_at[0][i] == cyc - 1) pend[i] = 1'b0;
          if (!pend[i] && $urandom_range(0, 2) == 0) begin
            pend[i] = 1'b1;
            ra[i] = $urandom;
            rb[i] = pick_b(ra[i]);
          end else if (pend[i] && m_active[0] != 0 && m_owner[0] == i && $urandom_range(0, 2) == 0) begin
            ra[i] = $urandom;
          end
        end
      end
      applyStimulus(pend[0], ra[0], rb[0], pend[1], ra[1], rb[1]);
      step_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
